// File: rtl/riscboy_ppu_blender_pkg.sv
// Shared constants for the RISCBoy PPU blender: state encodings and pixel width.
package riscboy_ppu_blender_pkg;

    localparam int W_RGB555 = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } blend_state_e;

endpackage

// File: rtl/riscboy_ppu_priority_mux.sv
// Fixed-priority layer select: lowest-index opaque layer wins, else the background colour.
module riscboy_ppu_priority_mux #(
    parameter int N_LAYERS  = 2,
    parameter int W_PIXDATA = 15,
    localparam int W_LAYER  = $clog2(N_LAYERS + 1)
) (
    input  logic [N_LAYERS-1:0]           alpha_i,
    input  logic [N_LAYERS*W_PIXDATA-1:0] pixdata_i,
    input  logic [W_PIXDATA-1:0]          bg_colour_i,
    output logic [W_PIXDATA-1:0]          colour_o,
    output logic [W_LAYER-1:0]            layer_o
);

    // Scan from the lowest priority upwards so the highest-priority opaque layer overwrites last.
    always_comb begin
        colour_o = bg_colour_i;
        layer_o  = W_LAYER'(N_LAYERS);
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (alpha_i[k]) begin
                colour_o = pixdata_i[k*W_PIXDATA +: W_PIXDATA];
                layer_o  = W_LAYER'(k);
            end
        end
    end

endmodule

// File: rtl/riscboy_ppu_blender.sv
// RISCBoy PPU blender: joins layer pixel streams, composites by priority, emits one pixel per x.
// Optional out_layer debug port is enabled by defining RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN.
module riscboy_ppu_blender
    import riscboy_ppu_blender_pkg::*;
#(
    parameter int N_LAYERS       = 2,
    parameter int W_PIXDATA      = W_RGB555,
    parameter int W_SCREEN_COORD = 9,
    localparam int W_LAYER       = $clog2(N_LAYERS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_line,
    input  logic [W_SCREEN_COORD-1:0]     cfg_line_last,
    input  logic [W_PIXDATA-1:0]          cfg_bg_colour,
    input  logic [N_LAYERS-1:0]           in_vld,
    output logic [N_LAYERS-1:0]           in_rdy,
    input  logic [N_LAYERS-1:0]           in_alpha,
    input  logic [N_LAYERS*W_PIXDATA-1:0] in_pixdata,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [W_PIXDATA-1:0]          out_pixdata,
    output logic [W_SCREEN_COORD-1:0]     out_x,
    output logic                          line_done
`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
    ,
    output logic [W_LAYER-1:0]            out_layer
`endif
);

    blend_state_e                state_q, state_d;
    logic [W_SCREEN_COORD-1:0]   x_q, x_d;
    logic                        out_vld_q, out_vld_d;
    logic [W_PIXDATA-1:0]        out_pix_q, out_pix_d;
    logic [W_SCREEN_COORD-1:0]   out_x_q, out_x_d;
    logic                        line_done_q, line_done_d;
    logic [W_PIXDATA-1:0]        comp_colour;
    logic                        take;

`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
    logic [W_LAYER-1:0]          comp_layer;
    logic [W_LAYER-1:0]          out_layer_q, out_layer_d;
`else
    logic [W_LAYER-1:0]          comp_layer_unused;
`endif

    riscboy_ppu_priority_mux #(
        .N_LAYERS  (N_LAYERS),
        .W_PIXDATA (W_PIXDATA)
    ) u_priority_mux (
        .alpha_i     (in_alpha),
        .pixdata_i   (in_pixdata),
        .bg_colour_i (cfg_bg_colour),
        .colour_o    (comp_colour),
`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
        .layer_o     (comp_layer)
`else
        .layer_o     (comp_layer_unused)
`endif
    );

    // All layers pop together, and only when the output register can accept the result.
    assign take   = (state_q == ST_RUN) && (&in_vld) && (!out_vld_q || out_rdy);
    assign in_rdy = {N_LAYERS{take}};

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        out_vld_d   = out_vld_q;
        out_pix_d   = out_pix_q;
        out_x_d     = out_x_q;
        line_done_d = 1'b0;
`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
        out_layer_d = out_layer_q;
`endif
        if (start_line) begin
            state_d   = ST_RUN;
            x_d       = '0;
            out_vld_d = 1'b0;
        end else if (take) begin
            out_vld_d = 1'b1;
            out_pix_d = comp_colour;
            out_x_d   = x_q;
`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
            out_layer_d = comp_layer;
`endif
            if (x_q == cfg_line_last) begin
                state_d = ST_DRAIN;
            end else begin
                x_d = x_q + 1'b1;
            end
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
            // In DRAIN the register can only hold the line's last pixel.
            if (state_q == ST_DRAIN) begin
                state_d     = ST_IDLE;
                line_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            out_vld_q   <= 1'b0;
            out_pix_q   <= '0;
            out_x_q     <= '0;
            line_done_q <= 1'b0;
`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
            out_layer_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            out_vld_q   <= out_vld_d;
            out_pix_q   <= out_pix_d;
            out_x_q     <= out_x_d;
            line_done_q <= line_done_d;
`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
            out_layer_q <= out_layer_d;
`endif
        end
    end

    assign out_vld     = out_vld_q;
    assign out_pixdata = out_pix_q;
    assign out_x       = out_x_q;
    assign line_done   = line_done_q;
`ifdef RISCBOY_PPU_BLENDER_LAYER_DEBUG_EN
    assign out_layer   = out_layer_q;
`endif

endmodule
